// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: command-driven controller for the 16-bit ALU datapath.
// It accepts one command at a time and drives the operands and the one-hot
// result-mux select for ALU_LAT cycles. It then captures the ALU result into
// the accumulator and returns the result with its flags on a valid/ready
// response port.
module alu_op_sequencer #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [15:0] cmd_operand,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [11:0] alu_sel,
  output logic        alu_sub,
  input  logic [15:0] alu_res,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_zero,
  output logic        rsp_ovf,
  output logic        rsp_err,
  output logic [15:0] acc
);

  localparam int unsigned DW      = 16;
  localparam int unsigned OPW     = 4;
  localparam int unsigned SELW    = 12;
  localparam int unsigned CW      = 4;
  localparam int unsigned NUM_OPS = 12;

  localparam logic [OPW-1:0] OP_ADD = OPW'(7);
  localparam logic [OPW-1:0] OP_SUB = OPW'(8);
  localparam logic [CW-1:0]  LAT_M1 = CW'(ALU_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          r_state,     w_state;
  logic [OPW-1:0]  r_op,        w_op;
  logic [CW-1:0]   r_cnt,       w_cnt;
  logic [DW-1:0]   r_acc,       w_acc;
  logic [DW-1:0]   r_alu_b,     w_alu_b;
  logic [SELW-1:0] r_alu_sel,   w_alu_sel;
  logic            r_alu_sub,   w_alu_sub;
  logic            r_cmd_ready, w_cmd_ready;
  logic            r_rsp_valid, w_rsp_valid;
  logic [DW-1:0]   r_rsp_data,  w_rsp_data;
  logic            r_rsp_zero,  w_rsp_zero;
  logic            r_rsp_ovf,   w_rsp_ovf;
  logic            r_rsp_err,   w_rsp_err;

  logic            w_ovf_add;
  logic            w_ovf_sub;
  logic            w_ovf;

  // Signed overflow of the result currently presented by the ALU
  always_comb begin
    w_ovf_add = (r_acc[DW-1] == r_alu_b[DW-1]) && (alu_res[DW-1] != r_acc[DW-1]);
    w_ovf_sub = (r_acc[DW-1] != r_alu_b[DW-1]) && (alu_res[DW-1] != r_acc[DW-1]);
    if (r_op == OP_ADD) begin
      w_ovf = w_ovf_add;
    end else if (r_op == OP_SUB) begin
      w_ovf = w_ovf_sub;
    end else begin
      w_ovf = 1'b0;
    end
  end

  // Next-state and next-register logic; every register holds unless changed
  always_comb begin
    w_state     = r_state;
    w_op        = r_op;
    w_cnt       = r_cnt;
    w_acc       = r_acc;
    w_alu_b     = r_alu_b;
    w_alu_sel   = r_alu_sel;
    w_alu_sub   = r_alu_sub;
    w_cmd_ready = r_cmd_ready;
    w_rsp_valid = r_rsp_valid;
    w_rsp_data  = r_rsp_data;
    w_rsp_zero  = r_rsp_zero;
    w_rsp_ovf   = r_rsp_ovf;
    w_rsp_err   = r_rsp_err;

    case (r_state)
      ST_IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          w_op        = cmd_op;
          w_alu_b     = cmd_operand;
          w_cmd_ready = 1'b0;
          if (cmd_op < OPW'(NUM_OPS)) begin
            w_state   = ST_EXEC;
            w_cnt     = LAT_M1;
            w_alu_sel = SELW'(1) << cmd_op;
            w_alu_sub = (cmd_op == OP_SUB);
          end else begin
            // Illegal opcode: report the untouched accumulator with an error
            w_state     = ST_RESP;
            w_rsp_valid = 1'b1;
            w_rsp_data  = r_acc;
            w_rsp_zero  = (r_acc == DW'(0));
            w_rsp_ovf   = 1'b0;
            w_rsp_err   = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        if (r_cnt == CW'(0)) begin
          w_state     = ST_RESP;
          w_acc       = alu_res;
          w_alu_sel   = SELW'(0);
          w_alu_sub   = 1'b0;
          w_rsp_valid = 1'b1;
          w_rsp_data  = alu_res;
          w_rsp_zero  = (alu_res == DW'(0));
          w_rsp_ovf   = w_ovf;
          w_rsp_err   = 1'b0;
        end else begin
          w_cnt = r_cnt - CW'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_state     = ST_IDLE;
          w_rsp_valid = 1'b0;
          w_cmd_ready = 1'b1;
        end
      end
      default: begin
        w_state     = ST_IDLE;
        w_alu_sel   = SELW'(0);
        w_alu_sub   = 1'b0;
        w_rsp_valid = 1'b0;
        w_cmd_ready = 1'b1;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op        <= OPW'(0);
      r_cnt       <= CW'(0);
      r_acc       <= DW'(0);
      r_alu_b     <= DW'(0);
      r_alu_sel   <= SELW'(0);
      r_alu_sub   <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= DW'(0);
      r_rsp_zero  <= 1'b0;
      r_rsp_ovf   <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_op        <= w_op;
      r_cnt       <= w_cnt;
      r_acc       <= w_acc;
      r_alu_b     <= w_alu_b;
      r_alu_sel   <= w_alu_sel;
      r_alu_sub   <= w_alu_sub;
      r_cmd_ready <= w_cmd_ready;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_data  <= w_rsp_data;
      r_rsp_zero  <= w_rsp_zero;
      r_rsp_ovf   <= w_rsp_ovf;
      r_rsp_err   <= w_rsp_err;
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign alu_a     = r_acc;
  assign alu_b     = r_alu_b;
  assign alu_sel   = r_alu_sel;
  assign alu_sub   = r_alu_sub;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_zero  = r_rsp_zero;
  assign rsp_ovf   = r_rsp_ovf;
  assign rsp_err   = r_rsp_err;
  assign acc       = r_acc;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (ALU_LAT=1 and ALU_LAT=3), each
// driving a behavioural ALU. Expected responses are queued at issue time and
// a monitor compares them on every response handshake.
module tb_alu_op_sequencer;

  typedef struct packed {
    logic [15:0] data;
    logic        zero;
    logic        ovf;
    logic        err;
  } rsp_t;

  logic        clk;
  logic        reset_n     [2];
  logic        cmd_valid   [2];
  logic        cmd_ready   [2];
  logic [3:0]  cmd_op      [2];
  logic [15:0] cmd_operand [2];
  logic [15:0] alu_a       [2];
  logic [15:0] alu_b       [2];
  logic [11:0] alu_sel     [2];
  logic        alu_sub     [2];
  logic [15:0] alu_res     [2];
  logic        rsp_valid   [2];
  logic        rsp_ready   [2];
  logic [15:0] rsp_data    [2];
  logic        rsp_zero    [2];
  logic        rsp_ovf     [2];
  logic        rsp_err     [2];
  logic [15:0] acc         [2];

  int   n_tests = 0;
  int   n_fail  = 0;
  rsp_t exp_q0[$];
  rsp_t exp_q1[$];

  alu_op_sequencer #(.ALU_LAT(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n[0]),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_op(cmd_op[0]), .cmd_operand(cmd_operand[0]),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_sel(alu_sel[0]),
    .alu_sub(alu_sub[0]), .alu_res(alu_res[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_data(rsp_data[0]), .rsp_zero(rsp_zero[0]),
    .rsp_ovf(rsp_ovf[0]), .rsp_err(rsp_err[0]), .acc(acc[0])
  );

  alu_op_sequencer #(.ALU_LAT(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n[1]),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_op(cmd_op[1]), .cmd_operand(cmd_operand[1]),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_sel(alu_sel[1]),
    .alu_sub(alu_sub[1]), .alu_res(alu_res[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_data(rsp_data[1]), .rsp_zero(rsp_zero[1]),
    .rsp_ovf(rsp_ovf[1]), .rsp_err(rsp_err[1]), .acc(acc[1])
  );

  // Behavioural ALU plus one-hot result mux; the adder honours alu_sub
  function automatic logic [15:0] alu_f(input logic [11:0] sel, input logic sub,
                                        input logic [15:0] a, input logic [15:0] b);
    logic [15:0] bb;
    bb = sub ? ~b : b;
    case (sel)
      12'h001: return a & b;
      12'h002: return a | b;
      12'h004: return ~a;
      12'h008: return a ^ b;
      12'h010: return ~(a & b);
      12'h020: return ~(a | b);
      12'h040: return ~(a ^ b);
      12'h080: return a + bb + 16'(sub);
      12'h100: return a + bb + 16'(sub);
      12'h200: return a >> b[3:0];
      12'h400: return a << b[3:0];
      12'h800: return 16'h0000;
      default: return 16'hDEAD;
    endcase
  endfunction

  assign alu_res[0] = alu_f(alu_sel[0], alu_sub[0], alu_a[0], alu_b[0]);
  assign alu_res[1] = alu_f(alu_sel[1], alu_sub[1], alu_a[1], alu_b[1]);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
  endtask

  // Scoreboard monitor: compares each response at its handshake
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rsp_valid[i] && rsp_ready[i]) begin
        rsp_t e;
        int   sz;
        sz = (i == 0) ? exp_q0.size() : exp_q1.size();
        if (sz == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_rsp[%0d]: got data 0x%0h, expected no response", i, rsp_data[i]);
        end else begin
          if (i == 0) e = exp_q0.pop_front();
          else        e = exp_q1.pop_front();
          chk($sformatf("rsp_data[%0d]", i), 32'(rsp_data[i]), 32'(e.data));
          chk($sformatf("rsp_zero[%0d]", i), 32'(rsp_zero[i]), 32'(e.zero));
          chk($sformatf("rsp_ovf[%0d]", i),  32'(rsp_ovf[i]),  32'(e.ovf));
          chk($sformatf("rsp_err[%0d]", i),  32'(rsp_err[i]),  32'(e.err));
        end
      end
    end
  end

  // Issue one command from a negedge; check the EXEC window and response latency.
  // Returns at the first negedge where rsp_valid is seen.
  task automatic issue(input int i, input logic [3:0] op, input logic [15:0] opnd,
                       input logic [15:0] exp_data, input logic exp_ovf,
                       input logic exp_err, input logic [11:0] exp_sel, input int exp_n);
    rsp_t e;
    int   n;
    bit   ok;
    e.data = exp_data;
    e.zero = (exp_data == 16'h0000);
    e.ovf  = exp_ovf;
    e.err  = exp_err;
    if (i == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
    cmd_valid[i]   = 1'b1;
    cmd_op[i]      = op;
    cmd_operand[i] = opnd;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (cmd_ready[i]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      cmd_valid[i] = 1'b0;
      fail_timeout("cmd_accept");
      return;
    end
    @(posedge clk);
    #1 cmd_valid[i] = 1'b0;
    n  = 0;
    ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      n++;
      if (rsp_valid[i]) begin
        ok = 1'b1;
        break;
      end
      chk("exec_sel", 32'(alu_sel[i]), 32'(exp_sel));
      chk("exec_sub", 32'(alu_sub[i]), 32'(op == 4'd8));
      chk("exec_b",   32'(alu_b[i]),   32'(opnd));
    end
    if (!ok) begin
      fail_timeout("rsp_valid");
      return;
    end
    chk("rsp_latency", 32'(n), 32'(exp_n));
    chk("rsp_sel_idle", 32'(alu_sel[i]), 32'h0);
  endtask

  // Complete the handshake at the next posedge and check the return to IDLE
  task automatic complete(input int i, input logic [15:0] exp_acc);
    @(posedge clk);
    @(negedge clk);
    chk("post_cmd_ready", 32'(cmd_ready[i]), 32'h1);
    chk("post_rsp_valid", 32'(rsp_valid[i]), 32'h0);
    chk("post_acc",       32'(acc[i]),       32'(exp_acc));
    chk("post_alu_a",     32'(alu_a[i]),     32'(exp_acc));
  endtask

  task automatic run(input int i, input logic [3:0] op, input logic [15:0] opnd,
                     input logic [15:0] exp_data, input logic exp_ovf,
                     input logic exp_err, input logic [11:0] exp_sel, input int exp_n);
    issue(i, op, opnd, exp_data, exp_ovf, exp_err, exp_sel, exp_n);
    complete(i, exp_data);
  endtask

  task automatic check_reset_state(input int i);
    chk("rst_cmd_ready", 32'(cmd_ready[i]), 32'h1);
    chk("rst_alu_sel",   32'(alu_sel[i]),   32'h0);
    chk("rst_alu_sub",   32'(alu_sub[i]),   32'h0);
    chk("rst_alu_b",     32'(alu_b[i]),     32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid[i]), 32'h0);
    chk("rst_rsp_data",  32'(rsp_data[i]),  32'h0);
    chk("rst_flags",     32'({rsp_zero[i], rsp_ovf[i], rsp_err[i]}), 32'h0);
    chk("rst_acc",       32'(acc[i]),       32'h0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      reset_n[i]     = 1'b0;
      cmd_valid[i]   = 1'b0;
      cmd_op[i]      = 4'd0;
      cmd_operand[i] = 16'h0;
      rsp_ready[i]   = 1'b1;
    end
    repeat (3) @(negedge clk);
    check_reset_state(0);
    check_reset_state(1);
    reset_n[0] = 1'b1;
    reset_n[1] = 1'b1;
    @(negedge clk);
    check_reset_state(0);
    check_reset_state(1);

    // ALU_LAT=1: add/sub sequence, overflow boundaries, illegal opcode, logic ops
    run(0, 4'd7,  16'h0005, 16'h0005, 1'b0, 1'b0, 12'h080, 2);
    run(0, 4'd7,  16'h0005, 16'h000A, 1'b0, 1'b0, 12'h080, 2);
    run(0, 4'd8,  16'h0003, 16'h0007, 1'b0, 1'b0, 12'h100, 2);
    run(0, 4'd11, 16'h0000, 16'h0000, 1'b0, 1'b0, 12'h800, 2);
    run(0, 4'd1,  16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 12'h002, 2);
    run(0, 4'd7,  16'h0001, 16'h8000, 1'b1, 1'b0, 12'h080, 2);
    run(0, 4'd8,  16'h0001, 16'h7FFF, 1'b1, 1'b0, 12'h100, 2);
    run(0, 4'd11, 16'h0000, 16'h0000, 1'b0, 1'b0, 12'h800, 2);
    run(0, 4'd1,  16'h1234, 16'h1234, 1'b0, 1'b0, 12'h002, 2);
    run(0, 4'd13, 16'h5555, 16'h1234, 1'b0, 1'b1, 12'h000, 1);
    run(0, 4'd2,  16'h0000, 16'hEDCB, 1'b0, 1'b0, 12'h004, 2);
    run(0, 4'd4,  16'h00FF, 16'hFF34, 1'b0, 1'b0, 12'h010, 2);
    run(0, 4'd10, 16'h0004, 16'hF340, 1'b0, 1'b0, 12'h400, 2);
    run(0, 4'd9,  16'h0008, 16'h00F3, 1'b0, 1'b0, 12'h200, 2);
    run(0, 4'd0,  16'h0F0F, 16'h0003, 1'b0, 1'b0, 12'h001, 2);
    run(0, 4'd5,  16'h0000, 16'hFFFC, 1'b0, 1'b0, 12'h020, 2);
    run(0, 4'd6,  16'hFFFC, 16'hFFFF, 1'b0, 1'b0, 12'h040, 2);
    run(0, 4'd7,  16'h0001, 16'h0000, 1'b0, 1'b0, 12'h080, 2);

    // ALU_LAT=3: XOR held for three cycles, then CLEAR
    run(1, 4'd1,  16'h00FF, 16'h00FF, 1'b0, 1'b0, 12'h002, 4);
    run(1, 4'd3,  16'hFFFF, 16'hFF00, 1'b0, 1'b0, 12'h008, 4);
    run(1, 4'd11, 16'h0000, 16'h0000, 1'b0, 1'b0, 12'h800, 4);

    // Response back-pressure with a toggling command stream
    rsp_ready[1] = 1'b0;
    issue(1, 4'd7, 16'h0011, 16'h0011, 1'b0, 1'b0, 12'h080, 4);
    cmd_op[1]      = 4'd11;
    cmd_operand[1] = 16'hAAAA;
    for (int k = 0; k < 5; k++) begin
      chk("stall_cmd_ready", 32'(cmd_ready[1]), 32'h0);
      chk("stall_rsp_valid", 32'(rsp_valid[1]), 32'h1);
      chk("stall_rsp_data",  32'(rsp_data[1]),  32'h0011);
      chk("stall_flags",     32'({rsp_zero[1], rsp_ovf[1], rsp_err[1]}), 32'h0);
      chk("stall_alu_sel",   32'(alu_sel[1]),   32'h0);
      cmd_valid[1] = (k % 2 == 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    cmd_valid[1] = 1'b0;
    rsp_ready[1] = 1'b1;
    complete(1, 16'h0011);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("no_second_rsp", 32'(rsp_valid[1]), 32'h0);
      chk("no_second_acc", 32'(acc[1]),       32'h0011);
      chk("no_second_sel", 32'(alu_sel[1]),   32'h0);
    end

    // Asynchronous reset while an ADD is executing
    cmd_valid[0]   = 1'b1;
    cmd_op[0]      = 4'd7;
    cmd_operand[0] = 16'h0005;
    @(posedge clk);
    #1 cmd_valid[0] = 1'b0;
    chk("pre_reset_sel", 32'(alu_sel[0]), 32'h080);
    #1 reset_n[0] = 1'b0;
    #1;
    chk("async_rst_sel",       32'(alu_sel[0]),   32'h0);
    chk("async_rst_rsp_valid", 32'(rsp_valid[0]), 32'h0);
    chk("async_rst_acc",       32'(acc[0]),       32'h0);
    @(negedge clk);
    reset_n[0] = 1'b1;
    @(negedge clk);
    chk("after_rst_cmd_ready", 32'(cmd_ready[0]), 32'h1);
    chk("after_rst_acc",       32'(acc[0]),       32'h0);
    chk("after_rst_rsp_valid", 32'(rsp_valid[0]), 32'h0);

    repeat (3) @(negedge clk);
    chk("sb_empty0", 32'(exp_q0.size()), 32'h0);
    chk("sb_empty1", 32'(exp_q1.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
